// File: rtl/timer_controller.sv
// timer_controller
//
// Four-state Moore timer. A request on b while idle opens a fixed three-cycle
// window during which x is high (On1, On2, On3), after which the machine
// returns to Off. b is only looked at in Off, so a held request restarts a
// new window right after the current one closes. x decodes the state register
// only, so it has no combinational path from b.
//
// Ports (declaration order kept as (x, b, clk, rst) for positional users):
//   x   - output, timer active; high in On1/On2/On3
//   b   - input,  start request, sampled on the rising edge while in Off
//   clk - input,  rising-edge clock
//   rst - input,  synchronous active-high reset, forces Off
module timer_controller (
    output logic x,
    input  logic b,
    input  logic clk,
    input  logic rst
);

    typedef enum logic [1:0] {
        StOff = 2'd0,
        StOn1 = 2'd1,
        StOn2 = 2'd2,
        StOn3 = 2'd3
    } state_e;

    // Initialiser gives a defined power-up state for benches that never reset.
    state_e PS = StOff;
    state_e ps_d;

    always_comb begin
        ps_d = PS;
        unique case (PS)
            StOff: ps_d = b ? StOn1 : StOff;
            StOn1: ps_d = StOn2;
            StOn2: ps_d = StOn3;
            StOn3: ps_d = StOff;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PS <= StOff;
        end else begin
            PS <= ps_d;
        end
    end

    assign x = (PS != StOff);

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller. Stimulus rows are applied 2 ns after each rising
// edge; each row pushes its hand-computed expected state and output into a
// queue. A separate monitor samples 1 ns after every rising edge and checks
// the oldest queued entry against the DUT.
module tb_timer_controller;

    logic clk;
    logic rst;
    logic b;
    logic x;

    timer_controller DUT (
        .x  (x),
        .b  (b),
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk; // first rising edge at t=5

    typedef struct {
        logic [1:0] ps;
        logic       x;
        int         idx;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus table: rst, b, expected PS after the next edge, expected x.
    localparam int NRows = 29;
    logic       t_rst [NRows];
    logic       t_b   [NRows];
    logic [1:0] t_ps  [NRows];
    logic       t_x   [NRows];

    task automatic row(input int i, input logic r, input logic bb, input logic [1:0] ps,
                       input logic xx);
        t_rst[i] = r;
        t_b[i]   = bb;
        t_ps[i]  = ps;
        t_x[i]   = xx;
    endtask

    initial begin
        // idle, no reset ever asserted yet
        row(0,  1'b0, 1'b0, 2'd0, 1'b0);
        row(1,  1'b0, 1'b0, 2'd0, 1'b0);
        // b held high: window, one Off cycle, restart
        row(2,  1'b0, 1'b1, 2'd1, 1'b1);
        row(3,  1'b0, 1'b1, 2'd2, 1'b1);
        row(4,  1'b0, 1'b1, 2'd3, 1'b1);
        row(5,  1'b0, 1'b1, 2'd0, 1'b0);
        row(6,  1'b0, 1'b1, 2'd1, 1'b1);
        row(7,  1'b0, 1'b1, 2'd2, 1'b1);
        row(8,  1'b0, 1'b0, 2'd3, 1'b1);
        row(9,  1'b0, 1'b0, 2'd0, 1'b0);
        // b low for six edges: no spurious start
        row(10, 1'b0, 1'b0, 2'd0, 1'b0);
        row(11, 1'b0, 1'b0, 2'd0, 1'b0);
        row(12, 1'b0, 1'b0, 2'd0, 1'b0);
        row(13, 1'b0, 1'b0, 2'd0, 1'b0);
        row(14, 1'b0, 1'b0, 2'd0, 1'b0);
        row(15, 1'b0, 1'b0, 2'd0, 1'b0);
        // reset in On2 with b high wins, then restart
        row(16, 1'b0, 1'b1, 2'd1, 1'b1);
        row(17, 1'b0, 1'b0, 2'd2, 1'b1);
        row(18, 1'b1, 1'b1, 2'd0, 1'b0);
        row(19, 1'b0, 1'b1, 2'd1, 1'b1);
        // b pulses mid-window: window not extended
        row(20, 1'b0, 1'b1, 2'd2, 1'b1);
        row(21, 1'b0, 1'b0, 2'd3, 1'b1);
        row(22, 1'b0, 1'b0, 2'd0, 1'b0);
        // reset in Off with b low, then reset in On3 with b high
        row(23, 1'b1, 1'b0, 2'd0, 1'b0);
        row(24, 1'b0, 1'b1, 2'd1, 1'b1);
        row(25, 1'b0, 1'b0, 2'd2, 1'b1);
        row(26, 1'b0, 1'b0, 2'd3, 1'b1);
        row(27, 1'b1, 1'b1, 2'd0, 1'b0);
        row(28, 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // Stimulus
    initial begin
        exp_t e;
        int   waited;
        rst = 1'b0;
        b   = 1'b0;
        // power-up state held through the first edge with b low
        e.ps = 2'd0; e.x = 1'b0; e.idx = -1;
        exp_q.push_back(e);
        @(posedge clk);
        for (int i = 0; i < NRows; i++) begin
            #2;
            rst = t_rst[i];
            b   = t_b[i];
            e.ps = t_ps[i]; e.x = t_x[i]; e.idx = i;
            exp_q.push_back(e);
            @(posedge clk);
        end
        #2;
        rst = 1'b0;
        b   = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 5) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Monitor
    initial begin
        exp_t       e;
        logic [1:0] got_ps;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                got_ps = DUT.PS;
                n_cmp++;
                if (got_ps !== e.ps) begin
                    n_fail++;
                    $display("FAIL ps row %0d t=%0t: got %0d, required %0d",
                             e.idx, $time, got_ps, e.ps);
                end
                n_cmp++;
                if (x !== e.x) begin
                    n_fail++;
                    $display("FAIL x row %0d t=%0t: got %b, required %b",
                             e.idx, $time, x, e.x);
                end
            end
        end
    end

endmodule
